image_bcast: RTL and testbench

//  Downstream of the image block: takes its pixel-group stream (image_bus/last/val/rdy) and

---
 rtl/image_bcast_pkg.sv | 25 ++
 rtl/image_bcast.sv | 164 ++++++++++++++++
 tb/tb_image_bcast.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/image_bcast_pkg.sv
// ============================================================================
// Module      : image_bcast_pkg
// Description : Shared constants for the image broadcast block. Holds the
//               cfg-bus register map entries of the image datapath
//               (CFG_IMG_WR / CFG_IMG_RD / CFG_IMG_BC) and the bit positions
//               decoded from a CFG_IMG_BC write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package image_bcast_pkg;

    // cfg-bus register map of the image datapath
    localparam int CFG_IMG_WR = 1;
    localparam int CFG_IMG_RD = 2;
    localparam int CFG_IMG_BC = 3;

    // Returns the index of the stats-clear bit (MSB of the cfg word)
    function automatic int stat_clr_bit(input int dwidth);
        return dwidth - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/image_bcast.sv
// ============================================================================
// Module      : image_bcast
// Description : Broadcasts every upstream image beat to LANE_NB kernel lanes.
//               A single hold register keeps the beat while each enabled lane
//               takes it on its own cycle; upstream advances once every
//               enabled lane has taken it. The lane-enable mask is written
//               over the cfg bus and only takes effect between packets.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               cfg_data/addr/valid      - cfg write port (CFG_IMG_BC)
//               image_bus/last/val/rdy   - upstream beat stream
//               lane_bus/last            - beat shared by all lanes
//               lane_val/rdy             - per-lane handshake
//               stat_beats/stat_pkts     - retired beat/packet counters
// Options     : IMG_BCAST_STATS_EN - enables the stat counters; otherwise
//               the stat ports are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module image_bcast
    import image_bcast_pkg::*;
#(
    parameter int CFG_DWIDTH = 32,
    parameter int CFG_AWIDTH = 5,
    parameter int GROUP_NB   = 4,
    parameter int IMG_WIDTH  = 16,
    parameter int LANE_NB    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CFG_DWIDTH-1:0]         cfg_data,
    input  logic [CFG_AWIDTH-1:0]         cfg_addr,
    input  logic                          cfg_valid,
    input  logic [GROUP_NB*IMG_WIDTH-1:0] image_bus,
    input  logic                          image_last,
    input  logic                          image_val,
    output logic                          image_rdy,
    output logic [GROUP_NB*IMG_WIDTH-1:0] lane_bus,
    output logic                          lane_last,
    output logic [LANE_NB-1:0]            lane_val,
    input  logic [LANE_NB-1:0]            lane_rdy,
    output logic [31:0]                   stat_beats,
    output logic [31:0]                   stat_pkts
);

    localparam int c_BUS_W = GROUP_NB * IMG_WIDTH;

    logic [c_BUS_W-1:0] r_buf_bus;
    logic               r_buf_last;
    logic               r_buf_val;
    logic [LANE_NB-1:0] r_done;
    logic               r_in_pkt;
    logic [LANE_NB-1:0] r_mask;
    logic [LANE_NB-1:0] r_mask_pend;
    logic               r_mask_set;

    logic [LANE_NB-1:0] w_lane_val;
    logic [LANE_NB-1:0] w_take;
    logic               w_complete;
    logic               w_load;
    logic               w_cfg_wr;
    logic               w_apply;
    logic               w_unused_cfg;

    // A beat is complete when every lane is either disabled, already done,
    // or taking it right now. With an all-zero mask this is true on the
    // first buffered cycle, so the stream drains without raising lane_val.
    always_comb begin
        w_lane_val = {LANE_NB{r_buf_val}} & r_mask & ~r_done;
        w_take     = w_lane_val & lane_rdy;
        w_complete = r_buf_val & (&(~r_mask | r_done | w_take));
    end

    // Combinational through lane_rdy so a completing beat is replaced on
    // the same edge (no bubble at full throughput).
    assign image_rdy = ~rst & (~r_buf_val | w_complete);
    assign w_load    = image_val & image_rdy;
    assign w_cfg_wr  = cfg_valid & (cfg_addr == CFG_AWIDTH'(CFG_IMG_BC));

    // The pending mask may only land on a packet boundary: either nothing is
    // buffered and no packet is open, or the last beat retires this cycle.
    assign w_apply = r_mask_set & ((~r_buf_val & ~r_in_pkt) | (w_complete & r_buf_last));

    assign lane_val  = w_lane_val;
    assign lane_bus  = r_buf_bus;
    assign lane_last = r_buf_last;

    // Only the low mask bits (and the clear bit, when stats exist) are
    // decoded; fold the whole word so the remaining bits are accounted for.
    assign w_unused_cfg = &{1'b0, cfg_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_val   <= 1'b0;
            r_done      <= '0;
            r_in_pkt    <= 1'b0;
            r_mask      <= '1;
            r_mask_pend <= '1;
            r_mask_set  <= 1'b0;
        end else begin
            if (w_load) begin
                r_buf_val <= 1'b1;
            end else if (w_complete) begin
                r_buf_val <= 1'b0;
            end

            r_done <= w_complete ? '0 : (r_done | w_take);

            if (w_complete) begin
                r_in_pkt <= ~r_buf_last;
            end

            if (w_apply) begin
                r_mask <= r_mask_pend;
            end

            // A write on the apply cycle wins: the new value stays pending.
            if (w_cfg_wr) begin
                r_mask_pend <= cfg_data[LANE_NB-1:0];
                r_mask_set  <= 1'b1;
            end else if (w_apply) begin
                r_mask_set  <= 1'b0;
            end
        end
    end

    // Payload needs no reset: it is only observed while r_buf_val is set.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_buf_bus  <= image_bus;
            r_buf_last <= image_last;
        end
    end

`ifdef IMG_BCAST_STATS_EN
    logic [31:0] r_stat_beats;
    logic [31:0] r_stat_pkts;
    logic        w_stat_clr;

    assign w_stat_clr = w_cfg_wr & cfg_data[stat_clr_bit(CFG_DWIDTH)];

    // A clear has priority; a beat retiring on the clear cycle is not counted.
    always_ff @(posedge clk) begin
        if (rst || w_stat_clr) begin
            r_stat_beats <= '0;
            r_stat_pkts  <= '0;
        end else if (w_complete) begin
            r_stat_beats <= r_stat_beats + 32'd1;
            if (r_buf_last) begin
                r_stat_pkts <= r_stat_pkts + 32'd1;
            end
        end
    end

    assign stat_beats = r_stat_beats;
    assign stat_pkts  = r_stat_pkts;
`else
    assign stat_beats = '0;
    assign stat_pkts  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_image_bcast.sv
// ============================================================================
// Module      : tb_image_bcast
// Description : Self-checking bench for image_bcast. Directed vector table,
//               hand-written throughput/reset sequences, then randomized
//               traffic checked against a per-lane expected-beat scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_image_bcast;
    import image_bcast_pkg::*;

    localparam int CFG_DWIDTH = 32;
    localparam int CFG_AWIDTH = 5;
    localparam int GROUP_NB   = 4;
    localparam int IMG_WIDTH  = 16;
    localparam int LANE_NB    = 4;
    localparam int BW         = GROUP_NB * IMG_WIDTH;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [CFG_DWIDTH-1:0] cfg_data = '0;
    logic [CFG_AWIDTH-1:0] cfg_addr = '0;
    logic                  cfg_valid = 1'b0;
    logic [BW-1:0]         image_bus = '0;
    logic                  image_last = 1'b0;
    logic                  image_val = 1'b0;
    logic                  image_rdy;
    logic [BW-1:0]         lane_bus;
    logic                  lane_last;
    logic [LANE_NB-1:0]    lane_val;
    logic [LANE_NB-1:0]    lane_rdy = '0;
    logic [31:0]           stat_beats;
    logic [31:0]           stat_pkts;

    image_bcast #(
        .CFG_DWIDTH(CFG_DWIDTH), .CFG_AWIDTH(CFG_AWIDTH), .GROUP_NB(GROUP_NB),
        .IMG_WIDTH(IMG_WIDTH), .LANE_NB(LANE_NB)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
        .image_bus(image_bus), .image_last(image_last), .image_val(image_val),
        .image_rdy(image_rdy),
        .lane_bus(lane_bus), .lane_last(lane_last), .lane_val(lane_val),
        .lane_rdy(lane_rdy),
        .stat_beats(stat_beats), .stat_pkts(stat_pkts)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Inputs change right after the falling edge; outputs are read #1 later.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [BW-1:0] bv(input int n);
        return BW'(64'hA5A5_0000_0000_0000) + BW'(n);
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic               iv;
        logic               il;
        logic [BW-1:0]      bus;
        logic [LANE_NB-1:0] rdy;
        logic               cv;
        logic [31:0]        cd;
        logic               erdy;
        logic [LANE_NB-1:0] elv;
        logic               cbus;
        logic [BW-1:0]      ebus;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic il, input logic [BW-1:0] bus,
                                input logic [3:0] rdy, input logic cv, input logic [31:0] cd,
                                input logic erdy, input logic [3:0] elv,
                                input logic cbus, input logic [BW-1:0] ebus);
        vec_t v;
        v.iv = iv; v.il = il; v.bus = bus; v.rdy = rdy; v.cv = cv; v.cd = cd;
        v.erdy = erdy; v.elv = elv; v.cbus = cbus; v.ebus = ebus;
        return v;
    endfunction

    vec_t tbl[18];

    // ---------------- scoreboard model ----------------
    typedef struct {
        logic [BW-1:0] bus;
        logic          last;
    } beat_t;

    beat_t              lq[LANE_NB][$];
    beat_t              cur;
    logic [LANE_NB-1:0] m_mask;
    logic [LANE_NB-1:0] pkt_mask;
    logic [LANE_NB-1:0] prev_pend;
    logic [BW-1:0]      prev_bus;
    logic               prev_last;
    bit                 have;
    bit                 pkt_first;
    int                 left;
    int                 n_beats;
    int                 n_pkts;

    task automatic check_lanes();
        beat_t e;
        for (int k = 0; k < LANE_NB; k++) begin
            if (prev_pend[k]) begin
                chk($sformatf("hold_val%0d", k), 64'(lane_val[k]), 64'd1);
                chk($sformatf("hold_bus%0d", k), 64'(lane_bus), 64'(prev_bus));
                chk($sformatf("hold_last%0d", k), 64'(lane_last), 64'(prev_last));
            end
            if (lane_val[k] && lane_rdy[k]) begin
                if (lq[k].size() == 0) begin
                    chk($sformatf("lane_extra%0d", k), 64'd1, 64'd0);
                end else begin
                    e = lq[k].pop_front();
                    chk($sformatf("lane_bus%0d", k), 64'(lane_bus), 64'(e.bus));
                    chk($sformatf("lane_last%0d", k), 64'(lane_last), 64'(e.last));
                end
            end
        end
        prev_pend = lane_val & ~lane_rdy;
        prev_bus  = lane_bus;
        prev_last = lane_last;
    endtask

    task automatic rand_cycle(input bit allow_new, input bit drain);
        if (!have && (left > 0 || allow_new)) begin
            if (left == 0) begin
                left      = $urandom_range(1, 4);
                pkt_first = 1'b1;
            end
            cur.bus  = {$urandom, $urandom};
            cur.last = (left == 1);
            have     = 1'b1;
        end
        image_val  = have && (drain || $urandom_range(0, 3) != 0);
        image_bus  = cur.bus;
        image_last = cur.last;
        lane_rdy   = drain ? '1 : LANE_NB'($urandom);
        cfg_valid  = 1'b0;
        cfg_addr   = CFG_AWIDTH'(CFG_IMG_BC);
        cfg_data   = '0;
        if (!drain && $urandom_range(0, 19) == 0) begin
            cfg_valid = 1'b1;
            cfg_data  = $urandom & 32'h0000_000F;
            if ($urandom_range(0, 3) == 0)
                cfg_addr = CFG_AWIDTH'(CFG_IMG_BC) ^ CFG_AWIDTH'($urandom_range(1, 31));
        end
        #1;
        check_lanes();
        if (image_val && image_rdy) begin
            // A packet is routed with the last mask written before its first beat.
            if (pkt_first) begin
                pkt_mask  = m_mask;
                pkt_first = 1'b0;
            end
            for (int k = 0; k < LANE_NB; k++)
                if (pkt_mask[k]) lq[k].push_back(cur);
            n_beats++;
            if (cur.last) n_pkts++;
            left--;
            have = 1'b0;
        end
        if (cfg_valid && cfg_addr == CFG_AWIDTH'(CFG_IMG_BC))
            m_mask = cfg_data[LANE_NB-1:0];
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1; image_val = 1'b0; cfg_valid = 1'b0; lane_rdy = '0;
        step(); step();
        rst = 1'b0;
    endtask

    initial begin : main
        int qleft;

        tbl[0]  = mk(1, 1, bv(0), 4'b0000, 0, 0,  1, 4'b0000, 0, '0);
        tbl[1]  = mk(0, 0, '0,    4'b0001, 0, 0,  0, 4'b1111, 1, bv(0));
        tbl[2]  = mk(0, 0, '0,    4'b0010, 0, 0,  0, 4'b1110, 1, bv(0));
        tbl[3]  = mk(0, 0, '0,    4'b0100, 0, 0,  0, 4'b1100, 1, bv(0));
        tbl[4]  = mk(0, 0, '0,    4'b1000, 0, 0,  1, 4'b1000, 1, bv(0));
        tbl[5]  = mk(0, 0, '0,    4'b0000, 1, 0,  1, 4'b0000, 0, '0);
        tbl[6]  = mk(1, 0, bv(1), 4'b0000, 0, 0,  1, 4'b0000, 0, '0);
        tbl[7]  = mk(1, 0, bv(2), 4'b0000, 0, 0,  1, 4'b0000, 0, '0);
        tbl[8]  = mk(1, 0, bv(3), 4'b0000, 0, 0,  1, 4'b0000, 0, '0);
        tbl[9]  = mk(1, 0, bv(4), 4'b0000, 0, 0,  1, 4'b0000, 0, '0);
        tbl[10] = mk(1, 1, bv(5), 4'b0000, 0, 0,  1, 4'b0000, 0, '0);
        tbl[11] = mk(0, 0, '0,    4'b0000, 1, 5,  1, 4'b0000, 0, '0);
        tbl[12] = mk(1, 1, bv(6), 4'b0000, 0, 0,  1, 4'b0000, 0, '0);
        tbl[13] = mk(0, 0, '0,    4'b0000, 0, 0,  0, 4'b0101, 1, bv(6));
        tbl[14] = mk(0, 0, '0,    4'b1111, 0, 0,  1, 4'b0101, 1, bv(6));
        tbl[15] = mk(0, 0, '0,    4'b0000, 0, 0,  1, 4'b0000, 0, '0);
        tbl[16] = mk(0, 0, '0,    4'b0000, 1, 15, 1, 4'b0000, 0, '0);
        tbl[17] = mk(0, 0, '0,    4'b0000, 0, 0,  1, 4'b0000, 0, '0);

        @(negedge clk);
        // ---- reset state ----
        #1;
        chk("rst_image_rdy", 64'(image_rdy), 64'd0);
        chk("rst_lane_val", 64'(lane_val), 64'd0);
        step(); step();
        rst = 1'b0;
        #1;
        chk("post_rst_rdy", 64'(image_rdy), 64'd1);
        chk("post_rst_lane_val", 64'(lane_val), 64'd0);
        chk("post_rst_beats", 64'(stat_beats), 64'd0);
        chk("post_rst_pkts", 64'(stat_pkts), 64'd0);

        // ---- throughput: 8-beat packet, all lanes ready ----
        for (int i = 0; i <= 8; i++) begin
            image_val  = (i < 8);
            image_bus  = bv(100 + i);
            image_last = (i == 7);
            lane_rdy   = '1;
            #1;
            chk($sformatf("tput_rdy%0d", i), 64'(image_rdy), 64'd1);
            chk($sformatf("tput_val%0d", i), 64'(lane_val), (i == 0) ? 64'd0 : 64'hF);
            if (i > 0) begin
                chk($sformatf("tput_bus%0d", i), 64'(lane_bus), 64'(bv(100 + i - 1)));
                chk($sformatf("tput_last%0d", i), 64'(lane_last), 64'(i == 8));
            end
            step();
        end
        image_val = 1'b0;
        #1;
        chk("tput_drained", 64'(lane_val), 64'd0);

        // ---- directed table ----
        for (int i = 0; i < 18; i++) begin
            image_val  = tbl[i].iv;
            image_last = tbl[i].il;
            image_bus  = tbl[i].bus;
            lane_rdy   = tbl[i].rdy;
            cfg_valid  = tbl[i].cv;
            cfg_addr   = CFG_AWIDTH'(CFG_IMG_BC);
            cfg_data   = tbl[i].cd;
            #1;
            chk($sformatf("tbl%0d_rdy", i), 64'(image_rdy), 64'(tbl[i].erdy));
            chk($sformatf("tbl%0d_val", i), 64'(lane_val), 64'(tbl[i].elv));
            if (tbl[i].cbus)
                chk($sformatf("tbl%0d_bus", i), 64'(lane_bus), 64'(tbl[i].ebus));
            step();
        end
        cfg_valid = 1'b0; image_val = 1'b0; lane_rdy = '0;

        // ---- reset with a partially taken beat ----
        cfg_valid = 1'b1; cfg_data = 32'h7; step();
        cfg_valid = 1'b0; step();
        image_val = 1'b1; image_bus = bv(200); image_last = 1'b0; step();
        image_val = 1'b0; lane_rdy = 4'b0011;
        #1;
        chk("rs_lane_val", 64'(lane_val), 64'h7);
        step();
        rst = 1'b1; lane_rdy = '0;
        #1;
        chk("rs_rdy_in_rst", 64'(image_rdy), 64'd0);
        step();
        #1;
        chk("rs_val_in_rst", 64'(lane_val), 64'd0);
        chk("rs_rdy_in_rst2", 64'(image_rdy), 64'd0);
        rst = 1'b0;
        #1;
        chk("rs_val_after", 64'(lane_val), 64'd0);
        chk("rs_rdy_after", 64'(image_rdy), 64'd1);
        image_val = 1'b1; image_bus = bv(201); image_last = 1'b1; step();
        image_val = 1'b0;
        #1;
        chk("rs_mask_restored", 64'(lane_val), 64'hF);
        chk("rs_new_bus", 64'(lane_bus), 64'(bv(201)));
        lane_rdy = '1; step();
        #1;
        chk("rs_done", 64'(lane_val), 64'd0);

        // ---- randomized traffic against the scoreboard ----
        do_reset();
        m_mask = '1; pkt_mask = '1; prev_pend = '0; prev_bus = '0; prev_last = 1'b0;
        have = 1'b0; pkt_first = 1'b0; left = 0; n_beats = 0; n_pkts = 0;
        for (int c = 0; c < 3000; c++) rand_cycle(1'b1, 1'b0);
        for (int c = 0; c < 400; c++) begin
            qleft = 0;
            for (int k = 0; k < LANE_NB; k++) qleft += lq[k].size();
            if (!have && left == 0 && qleft == 0 && lane_val == '0) break;
            rand_cycle(1'b0, 1'b1);
        end
        qleft = 0;
        for (int k = 0; k < LANE_NB; k++) qleft += lq[k].size();
        chk("drain_queues", 64'(qleft), 64'd0);
        chk("drain_src", 64'(left), 64'd0);
        image_val = 1'b0; cfg_valid = 1'b0; lane_rdy = '0;
        #1;

`ifdef IMG_BCAST_STATS_EN
        chk("stat_beats", 64'(stat_beats), 64'(n_beats));
        chk("stat_pkts", 64'(stat_pkts), 64'(n_pkts));
        cfg_valid = 1'b1; cfg_addr = CFG_AWIDTH'(CFG_IMG_BC); cfg_data = 32'h8000_000F;
        step();
        cfg_valid = 1'b0;
        #1;
        chk("stat_clr_beats", 64'(stat_beats), 64'd0);
        chk("stat_clr_pkts", 64'(stat_pkts), 64'd0);
`else
        chk("stat_beats_off", 64'(stat_beats), 64'd0);
        chk("stat_pkts_off", 64'(stat_pkts), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
